// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one 16x16 multiplier datapath between two requesters.
// Operands are held on mul_* for MUL_LAT cycles, then the product is returned with id, tag and flags.
module mul_share_ctrl #(
    parameter int MUL_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    input  logic             req0_signed,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    input  logic             req1_signed,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    output logic             mul_signed,
    input  logic [31:0]      mul_product,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [31:0]      rsp_product,
    output logic             rsp_zero,
    output logic             rsp_neg
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    localparam logic [3:0] LAT_INIT = 4'(MUL_LAT);

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [15:0]        mul_a_q, mul_a_d;
    logic [15:0]        mul_b_q, mul_b_d;
    logic               mul_signed_q, mul_signed_d;
    logic               id_q, id_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        product_q, product_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;

    logic               grant_id;
    logic               accept;

    // With both requesters pending, the one that did not win last time goes next.
    always_comb begin
        grant_id   = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
        req0_ready = rst_n & (state_q == ST_IDLE) & req0_valid & ~grant_id;
        req1_ready = rst_n & (state_q == ST_IDLE) & req1_valid & grant_id;
        accept     = req0_ready | req1_ready;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_signed_d = mul_signed_q;
        id_d         = id_q;
        tag_d        = tag_q;
        product_d    = product_q;
        zero_d       = zero_q;
        neg_d        = neg_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mul_a_d      = grant_id ? req1_a      : req0_a;
                    mul_b_d      = grant_id ? req1_b      : req0_b;
                    mul_signed_d = grant_id ? req1_signed : req0_signed;
                    tag_d        = grant_id ? req1_tag    : req0_tag;
                    id_d         = grant_id;
                    last_grant_d = grant_id;
                    cnt_d        = LAT_INIT;
                    state_d      = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Last count: the datapath output has settled for the held operands.
                if (cnt_q == 4'd1) begin
                    product_d = mul_product;
                    zero_d    = (mul_product == 32'd0);
                    neg_d     = mul_signed_q & mul_product[31];
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
            mul_a_q      <= 16'd0;
            mul_b_q      <= 16'd0;
            mul_signed_q <= 1'b0;
            id_q         <= 1'b0;
            tag_q        <= '0;
            product_q    <= 32'd0;
            zero_q       <= 1'b0;
            neg_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_signed_q <= mul_signed_d;
            id_q         <= id_d;
            tag_q        <= tag_d;
            product_q    <= product_d;
            zero_q       <= zero_d;
            neg_q        <= neg_d;
        end
    end

    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign mul_signed  = mul_signed_q;
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_id      = id_q;
    assign rsp_tag     = tag_q;
    assign rsp_product = product_q;
    assign rsp_zero    = zero_q;
    assign rsp_neg     = neg_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl: instance A runs MUL_LAT=1, instance B runs MUL_LAT=3.
// Both see the same request stimulus; each test observes one instance.
module tb_mul_share_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_signed, req1_signed;
    logic [3:0]  req0_tag, req1_tag;
    logic        rsp_ready;

    logic        a_req0_ready, a_req1_ready, a_mul_signed, a_rsp_valid, a_rsp_id, a_rsp_zero, a_rsp_neg;
    logic [15:0] a_mul_a, a_mul_b;
    logic [31:0] a_mul_product, a_rsp_product;
    logic [3:0]  a_rsp_tag;
    logic        b_req0_ready, b_req1_ready, b_mul_signed, b_rsp_valid, b_rsp_id, b_rsp_zero, b_rsp_neg;
    logic [15:0] b_mul_a, b_mul_b;
    logic [31:0] b_mul_product, b_rsp_product;
    logic [3:0]  b_rsp_tag;

    int tests_run = 0;
    int tests_failed = 0;

    // Stand-in for the Booth/Wallace datapath.
    function automatic logic [31:0] dp_model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [31:0] xa, xb;
        xa = s ? {{16{a[15]}}, a} : {16'h0000, a};
        xb = s ? {{16{b[15]}}, b} : {16'h0000, b};
        return xa * xb;
    endfunction

    always_comb a_mul_product = dp_model(a_mul_a, a_mul_b, a_mul_signed);
    always_comb b_mul_product = dp_model(b_mul_a, b_mul_b, b_mul_signed);

    mul_share_ctrl #(.MUL_LAT(1), .TAG_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_signed(req0_signed), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_signed(req1_signed), .req1_tag(req1_tag),
        .mul_a(a_mul_a), .mul_b(a_mul_b), .mul_signed(a_mul_signed), .mul_product(a_mul_product),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(a_rsp_id), .rsp_tag(a_rsp_tag),
        .rsp_product(a_rsp_product), .rsp_zero(a_rsp_zero), .rsp_neg(a_rsp_neg)
    );

    mul_share_ctrl #(.MUL_LAT(3), .TAG_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_signed(req0_signed), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_signed(req1_signed), .req1_tag(req1_tag),
        .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_signed(b_mul_signed), .mul_product(b_mul_product),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(b_rsp_id), .rsp_tag(b_rsp_tag),
        .rsp_product(b_rsp_product), .rsp_zero(b_rsp_zero), .rsp_neg(b_rsp_neg)
    );

    task automatic idle_inputs;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_signed = 0; req0_tag = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_signed = 0; req1_tag = 0;
    endtask

    task automatic apply_reset;
        rst_n = 0; idle_inputs(); rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    // Issues one op on instance A and waits for its response; returns readiness and capture latency.
    task automatic run_op_a(input bit id, input logic [15:0] a, input logic [15:0] b, input logic s,
                            input logic [3:0] tag, output bit rdy_ok, output int lat);
        if (id == 1'b0) begin
            req0_valid = 1; req0_a = a; req0_b = b; req0_signed = s; req0_tag = tag;
        end else begin
            req1_valid = 1; req1_a = a; req1_b = b; req1_signed = s; req1_tag = tag;
        end
        #1;
        rdy_ok = id ? (a_req1_ready && !a_req0_ready) : (a_req0_ready && !a_req1_ready);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        lat = 0;
        while (!a_rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 0; idle_inputs(); req0_valid = 1; req1_valid = 1; rsp_ready = 0;
        @(posedge clk); #1;
        tests_run++; if (a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready: got %b%b expected 00", a_req0_ready, a_req1_ready); end
        tests_run++; if (a_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b expected 0", a_rsp_valid); end
        tests_run++; if ({a_mul_a, a_mul_b, a_mul_signed} !== 33'd0) begin tests_failed++; $display("FAIL reset_mul: got %h %h %b expected 0 0 0", a_mul_a, a_mul_b, a_mul_signed); end
        tests_run++; if ({a_rsp_id, a_rsp_tag, a_rsp_product, a_rsp_zero, a_rsp_neg} !== 39'd0) begin tests_failed++; $display("FAIL reset_rsp_fields: got id=%b tag=%h prod=%h z=%b n=%b expected zeros", a_rsp_id, a_rsp_tag, a_rsp_product, a_rsp_zero, a_rsp_neg); end
        req0_valid = 0; req1_valid = 0; rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        bit ok; int lat;
        rsp_ready = 1;
        run_op_a(1'b0, 16'h0003, 16'h0004, 1'b0, 4'h5, ok, lat);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL basic_ready: got %b expected 1", ok); end
        tests_run++; if (lat != 1) begin tests_failed++; $display("FAIL basic_latency: got %0d expected 1", lat); end
        tests_run++; if (a_rsp_product !== 32'h0000000C) begin tests_failed++; $display("FAIL basic_product: got %h expected 0000000c", a_rsp_product); end
        tests_run++; if ({a_rsp_id, a_rsp_tag, a_rsp_zero, a_rsp_neg} !== {1'b0, 4'h5, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL basic_fields: got id=%b tag=%h z=%b n=%b expected id=0 tag=5 z=0 n=0", a_rsp_id, a_rsp_tag, a_rsp_zero, a_rsp_neg); end
        @(posedge clk); #1;
        tests_run++; if (a_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_rsp_done: got %b expected 0", a_rsp_valid); end
    endtask

    task automatic test_signed;
        bit ok; int lat;
        rsp_ready = 1;
        run_op_a(1'b1, 16'hFFF9, 16'h0003, 1'b1, 4'hA, ok, lat);
        tests_run++; if (ok !== 1'b1) begin tests_failed++; $display("FAIL signed_ready: got %b expected 1", ok); end
        tests_run++; if (a_rsp_product !== 32'hFFFFFFEB) begin tests_failed++; $display("FAIL signed_product: got %h expected ffffffeb", a_rsp_product); end
        tests_run++; if ({a_rsp_id, a_rsp_tag, a_rsp_zero, a_rsp_neg} !== {1'b1, 4'hA, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL signed_fields: got id=%b tag=%h z=%b n=%b expected id=1 tag=a z=0 n=1", a_rsp_id, a_rsp_tag, a_rsp_zero, a_rsp_neg); end
        @(posedge clk); #1;
    endtask

    task automatic test_flags;
        bit ok; int lat;
        rsp_ready = 1;
        run_op_a(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, 4'h3, ok, lat);
        tests_run++; if (a_rsp_product !== 32'hFFFE0001) begin tests_failed++; $display("FAIL unsigned_max_product: got %h expected fffe0001", a_rsp_product); end
        tests_run++; if (a_rsp_neg !== 1'b0 || a_rsp_zero !== 1'b0) begin tests_failed++; $display("FAIL unsigned_neg_masked: got n=%b z=%b expected n=0 z=0", a_rsp_neg, a_rsp_zero); end
        @(posedge clk); #1;
        run_op_a(1'b1, 16'h0000, 16'h8000, 1'b1, 4'hC, ok, lat);
        tests_run++; if (a_rsp_product !== 32'h0 || a_rsp_zero !== 1'b1 || a_rsp_neg !== 1'b0) begin tests_failed++; $display("FAIL zero_flag: got prod=%h z=%b n=%b expected 0 1 0", a_rsp_product, a_rsp_zero, a_rsp_neg); end
        @(posedge clk); #1;
    endtask

    task automatic test_arbitration;
        logic [3:0] grants; int n; int both_cnt;
        apply_reset();
        rsp_ready = 1; grants = 4'h0; n = 0; both_cnt = 0;
        req0_valid = 1; req0_a = 16'h0002; req0_b = 16'h0002; req0_tag = 4'h1;
        req1_valid = 1; req1_a = 16'h0005; req1_b = 16'h0005; req1_tag = 4'h2;
        #1;
        for (int c = 0; c < 60 && n < 4; c++) begin
            if (a_req0_ready && a_req1_ready) both_cnt++;
            if (a_req0_ready) begin grants[n] = 1'b0; n++; end
            else if (a_req1_ready) begin grants[n] = 1'b1; n++; end
            @(posedge clk); #1;
        end
        req0_valid = 0; req1_valid = 0;
        repeat (4) @(posedge clk); #1;
        tests_run++; if (n != 4) begin tests_failed++; $display("FAIL arb_grant_count: got %0d expected 4", n); end
        tests_run++; if (grants !== 4'b1010) begin tests_failed++; $display("FAIL arb_order: got g3..g0=%b expected 1010", grants); end
        tests_run++; if (both_cnt != 0) begin tests_failed++; $display("FAIL arb_both_ready: got %0d cycles expected 0", both_cnt); end
    endtask

    task automatic test_stall_lat3;
        int lat; int changes; int early_rdy; int stall_bad;
        apply_reset();
        rsp_ready = 0; changes = 0; early_rdy = 0; stall_bad = 0;
        req1_valid = 1; req1_a = 16'h1234; req1_b = 16'h0010; req1_signed = 0; req1_tag = 4'h7;
        #1;
        tests_run++; if (b_req1_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_grant: got %b expected 1", b_req1_ready); end
        @(posedge clk); #1;
        req1_valid = 0;
        req0_valid = 1; req0_a = 16'h0005; req0_b = 16'h0005; req0_tag = 4'h4;
        #1;
        lat = 0;
        while (!b_rsp_valid && lat < 20) begin
            if (b_mul_a !== 16'h1234 || b_mul_b !== 16'h0010) changes++;
            if (b_req0_ready || b_req1_ready) early_rdy++;
            @(posedge clk); #1;
            lat++;
        end
        tests_run++; if (lat != 3) begin tests_failed++; $display("FAIL lat3_capture: got %0d edges expected 3", lat); end
        tests_run++; if (changes != 0) begin tests_failed++; $display("FAIL lat3_mul_stable: got %0d changes expected 0", changes); end
        for (int i = 0; i < 5; i++) begin
            if (b_rsp_valid !== 1'b1 || b_rsp_product !== 32'h00012340 || b_rsp_tag !== 4'h7 || b_rsp_id !== 1'b1) stall_bad++;
            if (b_req0_ready || b_req1_ready) early_rdy++;
            @(posedge clk); #1;
        end
        tests_run++; if (stall_bad != 0) begin tests_failed++; $display("FAIL stall_rsp_hold: got %0d bad cycles expected 0 (prod=%h)", stall_bad, b_rsp_product); end
        rsp_ready = 1;
        #1;
        if (b_req0_ready || b_req1_ready) early_rdy++;
        tests_run++; if (early_rdy != 0) begin tests_failed++; $display("FAIL stall_no_early_ready: got %0d cycles expected 0", early_rdy); end
        @(posedge clk); #1;
        tests_run++; if (b_rsp_valid !== 1'b0 || b_req0_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_after_handshake: got valid=%b rdy0=%b expected 0 1", b_rsp_valid, b_req0_ready); end
        tests_run++; if (b_mul_a !== 16'h1234 || b_mul_b !== 16'h0010) begin tests_failed++; $display("FAIL mul_held_idle: got %h %h expected 1234 0010", b_mul_a, b_mul_b); end
        req0_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_in_wait;
        int seen;
        rsp_ready = 1; seen = 0;
        req0_valid = 1; req0_a = 16'h0002; req0_b = 16'h0003; req0_signed = 0; req0_tag = 4'h9;
        #1;
        @(posedge clk); #1;
        req0_valid = 0;
        tests_run++; if (b_mul_a !== 16'h0002 || b_rsp_valid !== 1'b0) begin tests_failed++; $display("FAIL rstwait_launch: got mul_a=%h valid=%b expected 0002 0", b_mul_a, b_rsp_valid); end
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        tests_run++; if ({b_mul_a, b_mul_b, b_rsp_product, b_rsp_tag, b_rsp_valid} !== 69'd0) begin tests_failed++; $display("FAIL rstwait_outputs: got mul=%h/%h prod=%h tag=%h valid=%b expected zeros", b_mul_a, b_mul_b, b_rsp_product, b_rsp_tag, b_rsp_valid); end
        for (int i = 0; i < 6; i++) begin
            if (b_rsp_valid) seen++;
            @(posedge clk); #1;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL rstwait_no_rsp: got %0d valid cycles expected 0", seen); end
        req0_valid = 1; req1_valid = 1;
        #1;
        tests_run++; if (b_req0_ready !== 1'b1 || b_req1_ready !== 1'b0) begin tests_failed++; $display("FAIL rstwait_first_grant: got rdy0=%b rdy1=%b expected 1 0", b_req0_ready, b_req1_ready); end
        req0_valid = 0; req1_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_boundary;
        int seen;
        apply_reset();
        rsp_ready = 1; seen = 0;
        req1_valid = 1; req1_a = 16'h0007;
        #2 req1_valid = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (a_rsp_valid || b_rsp_valid) seen++;
        end
        tests_run++; if (seen != 0) begin tests_failed++; $display("FAIL boundary_no_accept: got %0d valid cycles expected 0", seen); end
        tests_run++; if (a_mul_a !== 16'h0000) begin tests_failed++; $display("FAIL boundary_mul_untouched: got %h expected 0000", a_mul_a); end
    endtask

    initial begin
        rst_n = 0; idle_inputs(); rsp_ready = 0;
        test_reset();
        test_basic();
        test_signed();
        test_flags();
        test_arbitration();
        test_stall_lat3();
        test_reset_in_wait();
        test_boundary();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
